mem_bus_arbiter: RTL

Two-master arbiter for the shared memory bus. It grants the bus to either the instruction-fetch requester or the data requester and holds the grant for one complete stb/ack transaction. Data requests have priority, with a bounded anti-starvation guarantee for instruction fetch. The block sits between the CPU-side bus interface and the memory bus, and replaces ad-hoc chip-select gating with an explicit, registered grant.

---
 rtl/mem_bus_arbiter.sv | 151 +++++++++++++++
 1 files changed

// File: rtl/mem_bus_arbiter.sv
// mem_bus_arbiter: two-master (instruction fetch / data) arbiter for the shared
// memory bus. It holds a registered grant for one stb/ack transaction. Data has
// priority, and instruction fetch gets a bounded number of consecutive data
// grants before it is served.
// Optional: define BUS_TIMEOUT_EN to abort a transaction after TIMEOUT_CYCLES
// cycles without an ack. The granted master's err pulses for that one cycle.
module mem_bus_arbiter #(
    parameter int D_MAX_CONSEC   = 4,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        i_stb_i,
    input  logic [31:0] i_adr_i,
    output logic        i_ack_o,
    output logic        i_err_o,
    output logic [31:0] i_dat_o,
    input  logic        d_stb_i,
    input  logic        d_we_i,
    input  logic [31:0] d_adr_i,
    input  logic [31:0] d_dat_i,
    input  logic [3:0]  d_sel_i,
    output logic        d_ack_o,
    output logic        d_err_o,
    output logic [31:0] d_dat_o,
    output logic        bus_stb_o,
    output logic        bus_we_o,
    output logic [31:0] bus_adr_o,
    output logic [31:0] bus_dat_o,
    output logic [3:0]  bus_sel_o,
    input  logic [31:0] bus_dat_i,
    input  logic        bus_ack_i
);

    typedef enum logic [1:0] {IDLE, GNT_I, GNT_D} state_t;

    typedef struct packed {
        logic        stb;
        logic        we;
        logic [31:0] adr;
        logic [31:0] dat;
        logic [3:0]  sel;
    } bus_req_t;

    localparam logic [3:0] D_MAX = 4'(D_MAX_CONSEC);

    // Catch out-of-range parameters at elaboration.
    if (D_MAX_CONSEC < 1 || D_MAX_CONSEC > 15) begin : g_bad_dmax
        $error("mem_bus_arbiter: D_MAX_CONSEC must be 1..15");
    end
    if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 65535) begin : g_bad_to
        $error("mem_bus_arbiter: TIMEOUT_CYCLES must be 1..65535");
    end

    state_t     state_q, state_d;
    logic [3:0] consec_q, consec_d;
    logic       timeout;
    bus_req_t   i_req, d_req, bus_req;

`ifdef BUS_TIMEOUT_EN
    localparam logic [15:0] TO_LIM = 16'(TIMEOUT_CYCLES);
    logic [15:0] wait_q;

    // Wait counter: held at 0 in IDLE, so it starts from 0 on every grant entry.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i)
            wait_q <= '0;
        else if (state_q == IDLE)
            wait_q <= '0;
        else if (!bus_ack_i)
            wait_q <= wait_q + 16'd1;
    end

    assign timeout = (state_q != IDLE) && (wait_q == TO_LIM);
`else
    assign timeout = 1'b0;
`endif

    // State register and anti-starvation counter.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q  <= IDLE;
            consec_q <= '0;
        end else begin
            state_q  <= state_d;
            consec_q <= consec_d;
        end
    end

    // Arbitration in IDLE and release of the grant.
    always_comb begin
        state_d  = state_q;
        consec_d = consec_q;
        case (state_q)
            IDLE: begin
                if (d_stb_i && !(i_stb_i && consec_q == D_MAX)) begin
                    state_d = GNT_D;
                    // Reaching here with i_stb_i high implies consec_q < D_MAX,
                    // so the increment saturates at D_MAX by construction.
                    consec_d = i_stb_i ? consec_q + 4'd1 : 4'd0;
                end else if (i_stb_i) begin
                    state_d  = GNT_I;
                    consec_d = 4'd0;
                end
            end
            GNT_I: if (bus_ack_i || !i_stb_i || timeout) state_d = IDLE;
            GNT_D: if (bus_ack_i || !d_stb_i || timeout) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    assign i_req = '{stb: i_stb_i, we: 1'b0, adr: i_adr_i, dat: 32'h0, sel: 4'hF};
    assign d_req = '{stb: d_stb_i, we: d_we_i, adr: d_adr_i, dat: d_dat_i, sel: d_sel_i};

    // Bus mux: only the granted master reaches the bus, IDLE drives all zeros.
    always_comb begin
        bus_req = '0;
        case (state_q)
            GNT_I:   bus_req = i_req;
            GNT_D:   bus_req = d_req;
            default: bus_req = '0;
        endcase
        if (timeout) bus_req.stb = 1'b0;
    end

    assign {bus_stb_o, bus_we_o, bus_adr_o, bus_dat_o, bus_sel_o} = bus_req;

    // Responses go to the granted master only. An ack in the timeout cycle wins over err.
    always_comb begin
        i_ack_o = 1'b0;
        i_err_o = 1'b0;
        i_dat_o = '0;
        d_ack_o = 1'b0;
        d_err_o = 1'b0;
        d_dat_o = '0;
        case (state_q)
            GNT_I: begin
                i_ack_o = bus_ack_i;
                i_err_o = timeout && !bus_ack_i;
                i_dat_o = bus_dat_i;
            end
            GNT_D: begin
                d_ack_o = bus_ack_i;
                d_err_o = timeout && !bus_ack_i;
                d_dat_o = bus_dat_i;
            end
            default: ;
        endcase
    end

endmodule
